// File: rtl/types_def.sv
// types_def: shared slot, request and address types for the burst coalescer
package types_def;
   localparam int BG_W   = 2;
   localparam int BANK_W = 2;
   localparam int ROW_W  = 14;
   localparam int COL_W  = 10;

   typedef enum logic [2:0] {EMPTY, FILLING, CLOSED, DATA, RETURNING} coal_state_type;
   typedef enum logic {READ, WRITE} r_type;

   typedef struct packed {
      logic [BG_W-1:0]   bank_group;
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  column;
   } address_type;

   // Two addresses belong to the same burst when everything above the beat bits matches
   function automatic logic same_burst(input address_type a, input address_type b, input int beat_bits);
      return a.bank_group == b.bank_group && a.bank == b.bank && a.row == b.row &&
             (a.column >> beat_bits) == (b.column >> beat_bits);
   endfunction
endpackage

// File: rtl/slot_fifo.sv
// slot_fifo: queue of slot ids in the order their data phases completed
module slot_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [PW:0]      r_cnt;

   assign o_dout  = r_mem[r_rd];
   assign o_empty = r_cnt == '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop) r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
      end

   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/burst_coalescer.sv
// burst_coalescer: merges arbiter requests into bursts, runs their data phase
// and returns the individual entries in completion order
module burst_coalescer
   import types_def::*;
#(
   parameter int NO_OF_BURSTS  = 4,
   parameter int BURST_LENGTH  = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int INDEX_WIDTH   = 4,
   parameter int CLOSE_TIMEOUT = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             arb_valid,
   output logic                             arb_ready,
   input  address_type                      arb_addr,
   input  r_type                            arb_type,
   input  logic [DATA_WIDTH-1:0]            arb_data,
   input  logic [INDEX_WIDTH-1:0]           arb_index,
   output coal_state_type                   slot_state [NO_OF_BURSTS],
   output r_type                            slot_type  [NO_OF_BURSTS],
   output address_type                      slot_addr  [NO_OF_BURSTS],
   output logic [BURST_LENGTH-1:0]          slot_mask  [NO_OF_BURSTS],
   input  logic                             dp_start,
   input  logic [$clog2(NO_OF_BURSTS)-1:0]  dp_slot,
   input  logic                             dp_beat,
   input  logic [DATA_WIDTH-1:0]            dp_rd_data,
   output logic [DATA_WIDTH-1:0]            dp_wr_data,
   output logic                             ret_valid,
   input  logic                             ret_ready,
   output r_type                            ret_type,
   output logic [DATA_WIDTH-1:0]            ret_data,
   output logic [INDEX_WIDTH-1:0]           ret_index
);
   localparam int SW = $clog2(NO_OF_BURSTS);
   localparam int BW = $clog2(BURST_LENGTH);
   localparam int TW = $clog2(CLOSE_TIMEOUT + 1);

   coal_state_type          r_state [NO_OF_BURSTS];
   r_type                   r_kind  [NO_OF_BURSTS];
   address_type             r_addr  [NO_OF_BURSTS];
   logic [BURST_LENGTH-1:0] r_mask  [NO_OF_BURSTS];
   logic [BW-1:0]           r_beat  [NO_OF_BURSTS];
   logic [DATA_WIDTH-1:0]   r_data  [NO_OF_BURSTS][BURST_LENGTH];
   logic [INDEX_WIDTH-1:0]  r_index [NO_OF_BURSTS][BURST_LENGTH];
   logic [TW-1:0]           r_tmo;
   logic                    r_arm;

   logic                    w_fill_ok, w_free_ok, w_match, w_acc, w_close, w_tmo;
   logic [SW-1:0]           w_fill, w_free, w_tgt, w_head;
   logic [BW-1:0]           w_beat, w_cur, w_sel;
   logic [BURST_LENGTH-1:0] w_onehot, w_new_mask, w_rem, w_rest;
   address_type             w_base;
   logic                    w_dp, w_push, w_empty, w_ret_ok, w_fire, w_last;

   assign slot_state = r_state;
   assign slot_type  = r_kind;
   assign slot_addr  = r_addr;
   assign slot_mask  = r_mask;

   // Lowest-numbered EMPTY slot and the single FILLING slot, if any
   always_comb begin
      w_fill_ok = 1'b0;
      w_fill    = '0;
      w_free_ok = 1'b0;
      w_free    = '0;
      for (int i = NO_OF_BURSTS - 1; i >= 0; i--) begin
         if (r_state[i] == FILLING) begin
            w_fill_ok = 1'b1;
            w_fill    = SW'(i);
         end
         if (r_state[i] == EMPTY) begin
            w_free_ok = 1'b1;
            w_free    = SW'(i);
         end
      end
   end

   always_comb begin
      w_beat             = arb_addr.column[BW-1:0];
      w_base             = arb_addr;
      w_base.column[BW-1:0] = '0;
      w_onehot           = '0;
      w_onehot[w_beat]   = 1'b1;
      w_match            = w_fill_ok && same_burst(r_addr[w_fill], arb_addr, BW) &&
                           r_kind[w_fill] == arb_type && !r_mask[w_fill][w_beat];
      arb_ready          = w_match || w_free_ok;
      w_acc              = arb_valid && arb_ready;
      w_tgt              = w_match ? w_fill : w_free;
      w_new_mask         = r_mask[w_tgt] | w_onehot;
      w_close            = arb_valid && w_fill_ok && !w_match;
      w_tmo              = w_fill_ok && !arb_valid && r_tmo == TW'(CLOSE_TIMEOUT - 1);
   end

   // Data phase: one beat per dp_beat on the slot named by dp_slot
   always_comb begin
      w_cur      = r_beat[dp_slot];
      w_dp       = dp_beat && r_state[dp_slot] == DATA;
      w_push     = w_dp && w_cur == BW'(BURST_LENGTH - 1);
      dp_wr_data = (w_dp && r_kind[dp_slot] == WRITE && r_mask[dp_slot][w_cur]) ?
                   r_data[dp_slot][w_cur] : '0;
   end

   // Returned beats are cleared from the mask; the slot frees when none remain
   always_comb begin
      w_ret_ok     = !w_empty && r_state[w_head] == RETURNING;
      ret_valid    = w_ret_ok && r_arm;
      w_rem        = r_mask[w_head];
      w_sel        = '0;
      for (int i = BURST_LENGTH - 1; i >= 0; i--)
         if (w_rem[i]) w_sel = BW'(i);
      w_rest       = w_rem;
      w_rest[w_sel] = 1'b0;
      w_fire       = ret_valid && ret_ready;
      w_last       = w_fire && w_rest == '0;
      ret_type     = r_kind[w_head];
      ret_data     = r_data[w_head][w_sel];
      ret_index    = r_index[w_head][w_sel];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NO_OF_BURSTS; i++) begin
            r_state[i] <= EMPTY;
            r_mask[i]  <= '0;
            r_beat[i]  <= '0;
         end
         r_tmo <= '0;
         r_arm <= 1'b0;
      end else begin
         if (w_close || w_tmo) r_state[w_fill] <= CLOSED;
         if (w_acc) begin
            r_mask[w_tgt]  <= w_new_mask;
            r_state[w_tgt] <= &w_new_mask ? CLOSED : FILLING;
         end
         if (dp_start && r_state[dp_slot] == CLOSED) begin
            r_state[dp_slot] <= DATA;
            r_beat[dp_slot]  <= '0;
         end
         if (w_dp) begin
            r_beat[dp_slot] <= w_cur + 1'b1;
            if (w_push) r_state[dp_slot] <= RETURNING;
         end
         if (w_fire) begin
            r_mask[w_head][w_sel] <= 1'b0;
            if (w_last) r_state[w_head] <= EMPTY;
         end
         r_tmo <= (arb_valid || !w_fill_ok || w_tmo) ? '0 : r_tmo + 1'b1;
         r_arm <= w_ret_ok && !w_last;
      end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_index[w_tgt][w_beat] <= arb_index;
         if (arb_type == WRITE) r_data[w_tgt][w_beat] <= arb_data;
         if (!w_match) begin
            r_kind[w_tgt] <= arb_type;
            r_addr[w_tgt] <= w_base;
         end
      end
      if (w_dp && r_kind[dp_slot] == READ && r_mask[dp_slot][w_cur])
         r_data[dp_slot][w_cur] <= dp_rd_data;
   end

   slot_fifo #(.DEPTH(NO_OF_BURSTS), .WIDTH(SW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (dp_slot),
      .i_pop   (w_last),
      .o_dout  (w_head),
      .o_empty (w_empty)
   );

   a_dp_start: assert property (@(posedge clk) disable iff (!rst_n) dp_start |-> r_state[dp_slot] == CLOSED);
endmodule

// File: tb/tb_burst_coalescer.sv
// tb_burst_coalescer: directed checks of merging, closing, data phase,
// completion-order return and asynchronous reset
module tb_burst_coalescer;
   import types_def::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           arb_valid, arb_ready;
   address_type    arb_addr;
   r_type          arb_type;
   logic [15:0]    arb_data;
   logic [3:0]     arb_index;
   coal_state_type slot_state [4];
   r_type          slot_type  [4];
   address_type    slot_addr  [4];
   logic [15:0]    slot_mask  [4];
   logic           dp_start, dp_beat;
   logic [1:0]     dp_slot;
   logic [15:0]    dp_rd_data, dp_wr_data;
   logic           ret_valid, ret_ready;
   r_type          ret_type;
   logic [15:0]    ret_data;
   logic [3:0]     ret_index;
   int             n_chk = 0;
   int             n_fail = 0;

   always #5 clk = ~clk;

   burst_coalescer dut (
      .clk(clk), .rst_n(rst_n),
      .arb_valid(arb_valid), .arb_ready(arb_ready), .arb_addr(arb_addr), .arb_type(arb_type),
      .arb_data(arb_data), .arb_index(arb_index),
      .slot_state(slot_state), .slot_type(slot_type), .slot_addr(slot_addr), .slot_mask(slot_mask),
      .dp_start(dp_start), .dp_slot(dp_slot), .dp_beat(dp_beat), .dp_rd_data(dp_rd_data), .dp_wr_data(dp_wr_data),
      .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_type(ret_type), .ret_data(ret_data), .ret_index(ret_index)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      arb_valid = 1'b0; arb_addr = '0; arb_type = READ; arb_data = '0; arb_index = '0;
      dp_start = 1'b0; dp_beat = 1'b0; dp_slot = '0; dp_rd_data = '0; ret_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input r_type t, input int row, input int col, input int data, input int idx);
      arb_valid = 1'b1;
      arb_type = t;
      arb_addr = '0;
      arb_addr.row = ROW_W'(row);
      arb_addr.column = COL_W'(col);
      arb_data = 16'(data);
      arb_index = 4'(idx);
   endtask

   task automatic req(input r_type t, input int row, input int col, input int data, input int idx);
      set_req(t, row, col, data, idx);
      #1 chk("req_ready", arb_ready, 1);
      tick();
      arb_valid = 1'b0;
   endtask

   task automatic burst(input int s, input int base);
      dp_slot = 2'(s);
      dp_start = 1'b1;
      tick();
      dp_start = 1'b0;
      for (int j = 0; j < 16; j++) begin
         dp_beat = 1'b1;
         dp_rd_data = 16'(base + j);
         tick();
      end
      dp_beat = 1'b0;
   endtask

   initial begin
      int k;
      int exp_idx [3];
      int exp_dat [3];
      exp_idx = '{3, 4, 1};
      exp_dat = '{'hC001, 'hC006, 'hD002};

      // Reset state
      do_reset();
      for (int i = 0; i < 4; i++) chk("rst_state", slot_state[i], EMPTY);
      chk("rst_ready", arb_ready, 1);
      chk("rst_ret_valid", ret_valid, 0);
      chk("rst_mask", slot_mask[0], 0);

      // 16 back-to-back writes fill one slot, then a full data and return phase
      for (int i = 0; i < 16; i++) req(WRITE, 5, i, 'hA000 + i, i);
      chk("a_state", slot_state[0], CLOSED);
      chk("a_mask", slot_mask[0], 'hFFFF);
      chk("a_row", slot_addr[0].row, 5);
      chk("a_type", slot_type[0], WRITE);
      chk("a_other", slot_state[1], EMPTY);
      dp_slot = 2'd0;
      dp_start = 1'b1;
      tick();
      dp_start = 1'b0;
      chk("a_data_state", slot_state[0], DATA);
      for (int j = 0; j < 16; j++) begin
         dp_beat = 1'b1;
         #1 chk("a_wr_data", dp_wr_data, 'hA000 + j);
         tick();
      end
      dp_beat = 1'b0;
      chk("a_returning", slot_state[0], RETURNING);
      chk("a_ret_lat0", ret_valid, 0);
      tick();
      chk("a_ret_lat1", ret_valid, 1);
      chk("a_ret_type", ret_type, WRITE);
      ret_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk("a_ret_valid", ret_valid, 1);
         chk("a_ret_index", ret_index, j);
         chk("a_ret_data", ret_data, 'hA000 + j);
         tick();
      end
      ret_ready = 1'b0;
      chk("a_empty", slot_state[0], EMPTY);
      chk("a_ret_done", ret_valid, 0);

      // Same beat twice cannot merge: second read opens slot 1
      do_reset();
      req(READ, 7, 3, 0, 1);
      req(READ, 7, 3, 0, 2);
      chk("b_slot0", slot_state[0], CLOSED);
      chk("b_slot1", slot_state[1], FILLING);
      chk("b_mask1", slot_mask[1], 'h0008);

      // Idle timeout closes the filling slot, then a read data phase
      do_reset();
      req(READ, 2, 5, 0, 6);
      repeat (7) tick();
      chk("c_before_tmo", slot_state[0], FILLING);
      tick();
      chk("c_after_tmo", slot_state[0], CLOSED);
      burst(0, 'hB000);
      tick();
      chk("c_ret_valid", ret_valid, 1);
      chk("c_ret_data", ret_data, 'hB005);
      chk("c_ret_index", ret_index, 6);
      chk("c_ret_type", ret_type, READ);
      ret_ready = 1'b1;
      tick();
      ret_ready = 1'b0;
      chk("c_empty", slot_state[0], EMPTY);

      // All slots busy: held request waits until slot 0 fully returns
      do_reset();
      for (int i = 0; i < 4; i++) req(READ, i + 1, 0, 0, i);
      chk("d_slot3", slot_state[3], FILLING);
      set_req(READ, 9, 0, 0, 9);
      #1 chk("d_full_ready", arb_ready, 0);
      tick();
      chk("d_slot3_closed", slot_state[3], CLOSED);
      burst(0, 0);
      chk("d_ready_data", arb_ready, 0);
      tick();
      chk("d_ret_valid", ret_valid, 1);
      chk("d_ret_index", ret_index, 0);
      chk("d_ready_ret", arb_ready, 0);
      ret_ready = 1'b1;
      tick();
      ret_ready = 1'b0;
      chk("d_freed", slot_state[0], EMPTY);
      chk("d_ready_freed", arb_ready, 1);
      tick();
      arb_valid = 1'b0;
      chk("d_accepted", slot_state[0], FILLING);
      chk("d_acc_row", slot_addr[0].row, 9);

      // Slot 2 completes before slot 0 and must return first, stable under stall
      do_reset();
      req(READ, 1, 2, 0, 1);
      req(READ, 2, 0, 0, 2);
      req(READ, 3, 1, 0, 3);
      req(READ, 3, 6, 0, 4);
      chk("e_merge_mask", slot_mask[2], 'h0042);
      req(READ, 4, 0, 0, 5);
      chk("e_slot2_closed", slot_state[2], CLOSED);
      burst(2, 'hC000);
      burst(0, 'hD000);
      for (int c = 0; c < 5; c++) begin
         chk("e_stall_valid", ret_valid, 1);
         chk("e_stall_index", ret_index, 3);
         chk("e_stall_data", ret_data, 'hC001);
         tick();
      end
      ret_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 12 && k < 3; c++) begin
         if (ret_valid) begin
            chk("e_order_index", ret_index, exp_idx[k]);
            chk("e_order_data", ret_data, exp_dat[k]);
            k++;
         end
         tick();
      end
      ret_ready = 1'b0;
      chk("e_count", k, 3);
      chk("e_slot2_empty", slot_state[2], EMPTY);
      chk("e_slot0_empty", slot_state[0], EMPTY);

      // Asynchronous reset mid data phase
      do_reset();
      req(READ, 1, 0, 0, 1);
      req(WRITE, 2, 0, 'h1234, 2);
      req(READ, 3, 0, 0, 3);
      burst(0, 0);
      tick();
      chk("f_ret_valid", ret_valid, 1);
      dp_slot = 2'd1;
      dp_start = 1'b1;
      tick();
      dp_start = 1'b0;
      dp_beat = 1'b1;
      #1 chk("f_wr_data", dp_wr_data, 'h1234);
      chk("f_data_state", slot_state[1], DATA);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) chk("f_rst_state", slot_state[i], EMPTY);
      chk("f_rst_ret_valid", ret_valid, 0);
      chk("f_rst_ready", arb_ready, 1);
      chk("f_rst_wr_data", dp_wr_data, 0);
      chk("f_rst_mask", slot_mask[1], 0);
      dp_beat = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
